mod_n_updown_counter: RTL and testbench
=======================================

Name: mod_n_updown_counter

Overview:
- Parametrised synchronous modulo-N counter. It is the generalised successor of the team's fixed 4-bit T-flip-flop decade counter.
- Adds configurable modulus and width, up/down counting, synchronous load, wrap or saturate mode, optional rising-edge counting of an external pulse, and a carry/borrow output for cascading.
- Used in the irrigation controller for watering-interval timers, sensor-pulse tallies and multi-digit BCD display counters.

Parameters:
- MODULUS, 10, number of states; count range is 0..MODULUS-1; must be >= 2.
- WIDTH, 4, count width in bits; must satisfy MODULUS <= 2**WIDTH.
- EDGE_MODE, 1, 1 = count on each rising edge of pulse; 0 = pulse is a level count-enable, sampled every clk.
- SATURATE, 0, 0 = wrap at the terminal value; 1 = hold at the terminal value.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  global count enable.
- pulse  input  1  count source (edge or level per EDGE_MODE); synchronous to clk.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load strobe.
- load_value  input  WIDTH  value to load.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal count flag: count == MODULUS-1 when up=1; count == 0 when up=0.
- carry_out  output  1  cascade strobe: count event at the terminal value in wrap mode.

Behaviour:
- Reset state: count=0. pulse_q is set to 1, so a pulse held high across reset does not count. tc follows up (0 if up=1, 1 if up=0). carry_out=0.
- Priority per clock edge: reset > load > count event > hold.
- Count event:
  - EDGE_MODE=1: event = en & pulse & ~pulse_q. pulse_q is a register of pulse, updated every cycle including load cycles.
  - EDGE_MODE=0: event = en & pulse.
  - The count changes on the clock edge at which the event is seen; latency is one clk from the pulse rising to count updating.
- Up counting:
  - count < MODULUS-1: count+1.
  - count == MODULUS-1: 0 if SATURATE=0; hold if SATURATE=1.
- Down counting:
  - count > 0: count-1.
  - count == 0: MODULUS-1 if SATURATE=0; hold if SATURATE=1.
- Load: count <= load_value. Values >= MODULUS are clamped to MODULUS-1. An event in the same cycle is discarded; no carry is produced.
- tc is combinational from count and up.
- carry_out = event & tc & ~load & ~SATURATE (combinational). It is a one-cycle strobe in the same cycle as the wrapping edge.
- Cascading: feed carry_out into the next stage's pulse, with that stage built with EDGE_MODE=0 and the same clk. A chain stays fully synchronous with no ripple.
- Direction change takes effect on the next event. tc follows up immediately.
- en low: count holds. In EDGE_MODE=1, edges seen while en is low are lost; pulse_q keeps tracking.
- Reset asserted mid-operation: count returns to 0 on that edge. Any pending edge is discarded.
- Arithmetic stays within WIDTH bits with no intermediate overflow. The comparison with MODULUS-1 uses a WIDTH-bit constant.

Decomposition:
- Shared package irrigation_counter_pkg:
  - direction constants DIR_UP=1, DIR_DOWN=0
  - mode constants MODE_WRAP=0, MODE_SAT=1
  - default BCD_MODULUS=10
- One sub-module: pulse_edge_detect (clk, reset, in, rise).
  - Register of the input, reset to 1.
  - rise = in & ~q.
  - Instantiated only when EDGE_MODE=1.

Test Plan:
- Defaults (MODULUS=10, up=1, en=1, EDGE_MODE=1, SATURATE=0): 12 separate pulse rising edges -> count 1..9, 0, 1, 2. tc high at 9. carry_out high exactly one cycle, on the 9->0 edge.
- pulse held high for 5 cycles -> count increments by exactly 1. pulse high during reset and after its release -> no count until a fresh rising edge.
- Down counting with SATURATE=0 from count=0: one edge -> count=9 with carry_out strobe. With SATURATE=1 from count=0: edges -> count stays 0, tc=1, carry_out stays 0.
- load=1, load_value=7, coincident with a pulse edge -> count=7, no increment, carry_out=0. load_value=13 -> count clamped to 9.
- Cascade two instances (units EDGE_MODE=1, tens EDGE_MODE=0 driven by the units carry_out): 25 edges -> tens=2, units=5. 100 edges -> both 0.
- en=0 during edges -> count holds. Reset asserted at count=6 -> count=0 on the next clk; tc=0 with up=1.

Source files
------------

// File: rtl/irrigation_counter_pkg.sv
// -----------------------------------------------------------------------------
// irrigation_counter_pkg
//
// Purpose : Constants shared by the irrigation controller's counter blocks.
//           Direction and mode constants give readable names to the 1-bit
//           direction input and the SATURATE parameter. BCD_MODULUS is the
//           default modulus for decade display digits.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package irrigation_counter_pkg;

    // Values of the 'up' input.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Values of the SATURATE parameter.
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // One decimal digit.
    localparam int BCD_MODULUS = 10;

endpackage : irrigation_counter_pkg

// File: rtl/pulse_edge_detect.sv
// -----------------------------------------------------------------------------
// pulse_edge_detect
//
// Purpose : Rising-edge detector for a signal that is already synchronous to
//           clk. It produces a one-cycle 'rise' in the cycle where 'in' is high
//           and was low on the previous clock.
//           The history register resets to 1. A signal that is already high
//           when reset is released is therefore not reported as an edge.
//
// Ports   : clk   in  1  system clock
//           reset in  1  synchronous, active-high reset
//           in    in  1  signal to watch (synchronous to clk)
//           rise  out 1  combinational rising-edge strobe
// -----------------------------------------------------------------------------
module pulse_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic r_q;

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values, independent of the order the always blocks execute.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= 1'b1;
        end else begin
            r_q <= in;
        end
    end

    assign rise = in & ~r_q;

endmodule : pulse_edge_detect

// File: rtl/mod_n_updown_counter.sv
// -----------------------------------------------------------------------------
// mod_n_updown_counter
//
// Purpose : Parametrised synchronous modulo-N up/down counter. It supports
//           synchronous load with clamping, wrap or saturate at the ends, and
//           counting either rising edges or the level of 'pulse'. It also has
//           a carry/borrow strobe for building synchronous multi-stage chains.
//           This block generalises the old fixed 4-bit decade counter.
//
// Parameters:
//           MODULUS   number of states, count range 0..MODULUS-1 (>= 2)
//           WIDTH     count width, MODULUS <= 2**WIDTH
//           EDGE_MODE 1 = count rising edges of pulse, 0 = pulse is a level
//                     enable sampled every clock
//           SATURATE  MODE_WRAP = wrap at the ends, MODE_SAT = hold there
//
// Ports   : clk        in  1      system clock
//           reset      in  1      synchronous, active-high reset
//           en         in  1      global count enable
//           pulse      in  1      count source (edge or level)
//           up         in  1      DIR_UP = increment, DIR_DOWN = decrement
//           load       in  1      synchronous load strobe (beats counting)
//           load_value in  WIDTH  value to load, clamped to MODULUS-1
//           count      out WIDTH  current count, registered
//           tc         out 1      terminal count for the current direction
//           carry_out  out 1      one-cycle wrap strobe for cascading
//
// Cascading: connect carry_out to the pulse input of the next stage. Build that
//           stage with EDGE_MODE=0 and the same clk. Every stage then updates
//           on the same edge, with no ripple between stages.
// -----------------------------------------------------------------------------
module mod_n_updown_counter
    import irrigation_counter_pkg::*;
#(
    parameter int MODULUS   = BCD_MODULUS,
    parameter int WIDTH     = 4,
    parameter int EDGE_MODE = 1,
    parameter int SATURATE  = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             pulse,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             carry_out
);

    // The terminal value is a WIDTH-bit constant. Every compare and every
    // +/-1 therefore stays inside WIDTH bits.
    localparam logic [WIDTH-1:0] TERMINAL = WIDTH'(MODULUS - 1);
    localparam bit               SAT_EN   = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;
    logic [WIDTH-1:0] w_load_clamped;
    logic             w_source;
    logic             w_event;
    logic             w_at_top;
    logic             w_at_bottom;

    // ------------------------------------------------------------------
    // Count source: an edge detector, or the raw level.
    // ------------------------------------------------------------------
    generate
        if (EDGE_MODE == 1) begin : g_edge
            // The detector history keeps tracking pulse whatever en and load
            // do. Edges that arrive while en is low are therefore lost.
            pulse_edge_detect u_edge (
                .clk   (clk),
                .reset (reset),
                .in    (pulse),
                .rise  (w_source)
            );
        end else begin : g_level
            assign w_source = pulse;
        end
    endgenerate

    assign w_event = en & w_source;

    // ------------------------------------------------------------------
    // Terminal detection and cascade strobe.
    // ------------------------------------------------------------------
    assign w_at_top    = (r_count == TERMINAL);
    assign w_at_bottom = (r_count == '0);
    assign tc          = (up == DIR_UP) ? w_at_top : w_at_bottom;

    // The strobe fires only when the count really wraps. A load, a reset or
    // saturate mode each stops the wrap, so each one also stops the strobe.
    assign carry_out = w_event & tc & ~load & ~reset & ~SAT_EN;

    // Any value beyond the last state is clamped to the last state.
    assign w_load_clamped = (load_value > TERMINAL) ? TERMINAL : load_value;

    // ------------------------------------------------------------------
    // Next-count logic. Priority: load, then count event, then hold.
    // Reset is applied in the register block.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: assign a default before any branch so that no path through
        // this block leaves w_count_next unassigned (which would infer a latch).
        w_count_next = r_count;
        if (load) begin
            w_count_next = w_load_clamped;
        end else if (w_event) begin
            case (up)
                DIR_UP: begin
                    if (!w_at_top) begin
                        w_count_next = r_count + 1'b1;
                    end else if (!SAT_EN) begin
                        w_count_next = '0;
                    end
                end
                DIR_DOWN: begin
                    if (!w_at_bottom) begin
                        w_count_next = r_count - 1'b1;
                    end else if (!SAT_EN) begin
                        w_count_next = TERMINAL;
                    end
                end
                default: w_count_next = r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign count = r_count;

endmodule : mod_n_updown_counter

// File: tb/tb_mod_n_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_n_updown_counter
//
// Four counters share the stimulus:
//   0 units : MODULUS 10, edge mode, wrap       (default build)
//   1 tens  : MODULUS 10, level mode, wrap      (pulse = units carry_out)
//   2 sat   : MODULUS 10, edge mode, saturate
//   3 odd   : MODULUS 12, level mode, wrap
// Directed scenarios check values written out by hand. A randomized run checks
// every counter on every cycle against an arithmetic reference model.
// Inputs change 1 time unit after a rising edge. Outputs are sampled 1 unit
// later, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_mod_n_updown_counter;

    localparam int N = 4;
    localparam int MODS  [N] = '{10, 10, 10, 12};
    localparam bit EDGES [N] = '{1'b1, 1'b0, 1'b1, 1'b0};
    localparam bit SATS  [N] = '{1'b0, 1'b0, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       reset, en, pulse, up, load;
    logic [3:0] load_value;
    logic       tens_en, tens_load;
    logic [3:0] tens_lv;

    logic [3:0] cnt_u, cnt_t, cnt_s, cnt_o;
    logic       tc_u, tc_t, tc_s, tc_o;
    logic       c_u, c_t, c_s, c_o;

    int checks = 0;
    int errors = 0;

    assign tens_en   = 1'b1;
    assign tens_load = 1'b0;
    assign tens_lv   = 4'd0;

    always #5 clk = ~clk;

    mod_n_updown_counter #(.MODULUS(10), .WIDTH(4), .EDGE_MODE(1), .SATURATE(0)) u_units (
        .clk(clk), .reset(reset), .en(en), .pulse(pulse), .up(up), .load(load),
        .load_value(load_value), .count(cnt_u), .tc(tc_u), .carry_out(c_u));

    mod_n_updown_counter #(.MODULUS(10), .WIDTH(4), .EDGE_MODE(0), .SATURATE(0)) u_tens (
        .clk(clk), .reset(reset), .en(tens_en), .pulse(c_u), .up(up), .load(tens_load),
        .load_value(tens_lv), .count(cnt_t), .tc(tc_t), .carry_out(c_t));

    mod_n_updown_counter #(.MODULUS(10), .WIDTH(4), .EDGE_MODE(1), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .en(en), .pulse(pulse), .up(up), .load(load),
        .load_value(load_value), .count(cnt_s), .tc(tc_s), .carry_out(c_s));

    mod_n_updown_counter #(.MODULUS(12), .WIDTH(4), .EDGE_MODE(0), .SATURATE(0)) u_odd (
        .clk(clk), .reset(reset), .en(en), .pulse(pulse), .up(up), .load(load),
        .load_value(load_value), .count(cnt_o), .tc(tc_o), .carry_out(c_o));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves every counter at 0 and the edge histories low.
    task automatic do_reset();
        reset = 1'b1; en = 1'b1; up = 1'b1; pulse = 1'b0; load = 1'b0; load_value = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic edges(input int n);
        for (int k = 0; k < n; k++) begin
            pulse = 1'b1; tick();
            pulse = 1'b0; tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; up = 1'b1; pulse = 1'b1; load = 1'b0; load_value = '0;
        tick(); tick();
        checks++; if (cnt_u !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", cnt_u); end
        checks++; if (tc_u !== 1'b0) begin errors++; $display("FAIL reset_tc_up: got %b expected 0", tc_u); end
        checks++; if (c_u !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", c_u); end
        // pulse still high when reset is released: this is not an edge
        reset = 1'b0;
        tick(); tick();
        checks++; if (cnt_u !== 4'd0) begin errors++; $display("FAIL held_across_reset: got %0d expected 0", cnt_u); end
        checks++; if (cnt_s !== 4'd0) begin errors++; $display("FAIL held_across_reset_sat: got %0d expected 0", cnt_s); end
        up = 1'b0; #1;
        checks++; if (tc_u !== 1'b1) begin errors++; $display("FAIL tc_follows_up: got %b expected 1", tc_u); end
        up = 1'b1;
        pulse = 1'b0; tick();
        pulse = 1'b1; tick();
        checks++; if (cnt_u !== 4'd1) begin errors++; $display("FAIL fresh_edge_after_reset: got %0d expected 1", cnt_u); end
        pulse = 1'b0; tick();
    endtask

    task automatic test_edge_count();
        bit exp_tc;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            pulse = 1'b1; #1;
            exp_tc = ((k - 1) % 10 == 9);
            checks++; if (tc_u !== exp_tc) begin errors++; $display("FAIL edge_tc k=%0d: got %b expected %b", k, tc_u, exp_tc); end
            checks++; if (c_u !== exp_tc) begin errors++; $display("FAIL edge_carry k=%0d: got %b expected %b", k, c_u, exp_tc); end
            tick();
            checks++; if (cnt_u !== 4'(k % 10)) begin errors++; $display("FAIL edge_count k=%0d: got %0d expected %0d", k, cnt_u, k % 10); end
            pulse = 1'b0; tick();
            checks++; if (c_u !== 1'b0) begin errors++; $display("FAIL edge_carry_idle k=%0d: got %b expected 0", k, c_u); end
        end
        checks++; if (cnt_t !== 4'd1) begin errors++; $display("FAIL edge_tens: got %0d expected 1", cnt_t); end
    endtask

    task automatic test_held_pulse();
        do_reset();
        pulse = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (cnt_u !== 4'd1) begin errors++; $display("FAIL held_pulse cycle=%0d: got %0d expected 1", k, cnt_u); end
        end
        checks++; if (cnt_s !== 4'd1) begin errors++; $display("FAIL held_pulse_sat: got %0d expected 1", cnt_s); end
        checks++; if (cnt_o !== 4'd5) begin errors++; $display("FAIL level_mode_count: got %0d expected 5", cnt_o); end
        pulse = 1'b0; tick();
    endtask

    task automatic test_down();
        do_reset();
        up = 1'b0; pulse = 1'b1; #1;
        checks++; if (tc_u !== 1'b1) begin errors++; $display("FAIL down_tc_at_0: got %b expected 1", tc_u); end
        checks++; if (c_u !== 1'b1) begin errors++; $display("FAIL down_borrow: got %b expected 1", c_u); end
        checks++; if (tc_s !== 1'b1) begin errors++; $display("FAIL sat_tc_at_0: got %b expected 1", tc_s); end
        checks++; if (c_s !== 1'b0) begin errors++; $display("FAIL sat_no_borrow: got %b expected 0", c_s); end
        tick();
        checks++; if (cnt_u !== 4'd9) begin errors++; $display("FAIL down_wrap: got %0d expected 9", cnt_u); end
        checks++; if (cnt_s !== 4'd0) begin errors++; $display("FAIL sat_hold_0: got %0d expected 0", cnt_s); end
        checks++; if (cnt_t !== 4'd9) begin errors++; $display("FAIL tens_borrow: got %0d expected 9", cnt_t); end
        pulse = 1'b0; tick();
        pulse = 1'b1; #1;
        checks++; if (c_u !== 1'b0) begin errors++; $display("FAIL down_no_borrow_at_9: got %b expected 0", c_u); end
        checks++; if (c_s !== 1'b0) begin errors++; $display("FAIL sat_no_borrow_2: got %b expected 0", c_s); end
        tick();
        checks++; if (cnt_u !== 4'd8) begin errors++; $display("FAIL down_step: got %0d expected 8", cnt_u); end
        checks++; if (cnt_s !== 4'd0) begin errors++; $display("FAIL sat_hold_0_again: got %0d expected 0", cnt_s); end
        checks++; if (tc_s !== 1'b1) begin errors++; $display("FAIL sat_tc_hold: got %b expected 1", tc_s); end
        pulse = 1'b0; up = 1'b1; tick();
    endtask

    task automatic test_load();
        do_reset();
        load = 1'b1; load_value = 4'd13; tick();
        checks++; if (cnt_u !== 4'd9) begin errors++; $display("FAIL load_clamp: got %0d expected 9", cnt_u); end
        checks++; if (cnt_o !== 4'd11) begin errors++; $display("FAIL load_clamp_mod12: got %0d expected 11", cnt_o); end
        // load together with an edge while sitting at the terminal value
        load_value = 4'd7; pulse = 1'b1; #1;
        checks++; if (c_u !== 1'b0) begin errors++; $display("FAIL load_blocks_carry: got %b expected 0", c_u); end
        tick();
        checks++; if (cnt_u !== 4'd7) begin errors++; $display("FAIL load_beats_edge: got %0d expected 7", cnt_u); end
        checks++; if (cnt_s !== 4'd7) begin errors++; $display("FAIL load_sat: got %0d expected 7", cnt_s); end
        pulse = 1'b0; load_value = 4'd13; tick();
        load = 1'b0; pulse = 1'b1; #1;
        checks++; if (c_u !== 1'b1) begin errors++; $display("FAIL carry_after_load: got %b expected 1", c_u); end
        checks++; if (c_s !== 1'b0) begin errors++; $display("FAIL sat_no_carry: got %b expected 0", c_s); end
        checks++; if (tc_s !== 1'b1) begin errors++; $display("FAIL sat_tc_at_9: got %b expected 1", tc_s); end
        tick();
        checks++; if (cnt_u !== 4'd0) begin errors++; $display("FAIL wrap_after_load: got %0d expected 0", cnt_u); end
        checks++; if (cnt_s !== 4'd9) begin errors++; $display("FAIL sat_hold_9: got %0d expected 9", cnt_s); end
        pulse = 1'b0; tick();
    endtask

    task automatic test_cascade();
        do_reset();
        edges(25);
        checks++; if (cnt_u !== 4'd5) begin errors++; $display("FAIL cascade25_units: got %0d expected 5", cnt_u); end
        checks++; if (cnt_t !== 4'd2) begin errors++; $display("FAIL cascade25_tens: got %0d expected 2", cnt_t); end
        edges(75);
        checks++; if (cnt_u !== 4'd0) begin errors++; $display("FAIL cascade100_units: got %0d expected 0", cnt_u); end
        checks++; if (cnt_t !== 4'd0) begin errors++; $display("FAIL cascade100_tens: got %0d expected 0", cnt_t); end
    endtask

    task automatic test_enable_and_reset();
        do_reset();
        edges(6);
        checks++; if (cnt_u !== 4'd6) begin errors++; $display("FAIL six_edges: got %0d expected 6", cnt_u); end
        en = 1'b0;
        edges(3);
        checks++; if (cnt_u !== 4'd6) begin errors++; $display("FAIL en_low_hold: got %0d expected 6", cnt_u); end
        // an edge that arrives while en is low is not counted later
        pulse = 1'b1; tick();
        en = 1'b1; tick();
        checks++; if (cnt_u !== 4'd6) begin errors++; $display("FAIL lost_edge: got %0d expected 6", cnt_u); end
        pulse = 1'b0; tick();
        reset = 1'b1; pulse = 1'b1; tick();
        checks++; if (cnt_u !== 4'd0) begin errors++; $display("FAIL midrun_reset: got %0d expected 0", cnt_u); end
        reset = 1'b0; pulse = 1'b0; tick();
        checks++; if (cnt_u !== 4'd0) begin errors++; $display("FAIL after_reset_count: got %0d expected 0", cnt_u); end
        checks++; if (tc_u !== 1'b0) begin errors++; $display("FAIL after_reset_tc: got %b expected 0", tc_u); end
    endtask

    task automatic test_random();
        int         m_cnt [N];
        bit         m_prev [N];
        int         nxt [N];
        bit         nprev [N];
        bit         ecar [N];
        logic [3:0] oc [N];
        logic       ot [N];
        logic       oy [N];
        do_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_prev[i] = 1'b0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset      = ($urandom_range(0, 63) == 0);
            en         = ($urandom_range(0, 3) != 0);
            pulse      = $urandom_range(0, 1) == 1;
            up         = ($urandom_range(0, 7) == 0) ? ~up : up;
            load       = ($urandom_range(0, 15) == 0);
            load_value = 4'($urandom);
            #1;
            oc = '{cnt_u, cnt_t, cnt_s, cnt_o};
            ot = '{tc_u, tc_t, tc_s, tc_o};
            oy = '{c_u, c_t, c_s, c_o};
            for (int i = 0; i < N; i++) begin
                bit ien, ip, ild, ev, etc;
                int lv, m, top;
                m   = m_cnt[i];
                top = MODS[i] - 1;
                ien = (i == 1) ? 1'b1 : en;
                ip  = (i == 1) ? ecar[0] : pulse;
                ild = (i == 1) ? 1'b0 : load;
                lv  = (i == 1) ? 0 : int'(load_value);
                ev  = EDGES[i] ? (ien && ip && !m_prev[i]) : (ien && ip);
                etc = up ? (m == top) : (m == 0);
                ecar[i] = !reset && ev && etc && !ild && !SATS[i];
                if (reset)      nxt[i] = 0;
                else if (ild)   nxt[i] = (lv > top) ? top : lv;
                else if (!ev)   nxt[i] = m;
                else if (up)    nxt[i] = SATS[i] ? ((m == top) ? m : m + 1) : (m + 1) % MODS[i];
                else            nxt[i] = SATS[i] ? ((m == 0) ? 0 : m - 1) : (m + MODS[i] - 1) % MODS[i];
                nprev[i] = reset ? 1'b1 : ip;
                checks++; if (oc[i] !== 4'(m)) begin errors++; $display("FAIL rand_count inst=%0d cyc=%0d: got %0d expected %0d", i, cyc, oc[i], m); end
                checks++; if (ot[i] !== etc) begin errors++; $display("FAIL rand_tc inst=%0d cyc=%0d: got %b expected %b", i, cyc, ot[i], etc); end
                checks++; if (oy[i] !== ecar[i]) begin errors++; $display("FAIL rand_carry inst=%0d cyc=%0d: got %b expected %b", i, cyc, oy[i], ecar[i]); end
            end
            tick();
            m_cnt  = nxt;
            m_prev = nprev;
        end
        reset = 1'b0; load = 1'b0; pulse = 1'b0; en = 1'b1; up = 1'b1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; pulse = 1'b0; up = 1'b1; load = 1'b0; load_value = '0;
        tick();
        test_reset();
        test_edge_count();
        test_held_pulse();
        test_down();
        test_load();
        test_cascade();
        test_enable_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "time limit reached");
    end

endmodule : tb_mod_n_updown_counter
